// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared types and constants for the fetch-side PC redirect unit.
package pc_redirect_unit_pkg;
   typedef enum logic [1:0] {RUN, FLUSH_S, MEM_WAIT} state_t;
   localparam int          INSTR_BYTES   = 4;
   localparam int          CNT_W         = 3;
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'(INSTR_BYTES);
   endfunction
endpackage

// File: rtl/pc_redirect_unit_redirect_flush_counter.sv
// redirect_flush_counter: down-counter that keeps the flush asserted for the
// cycles following a redirect; reset wins over a same-cycle load.
module redirect_flush_counter
   import pc_redirect_unit_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_depth,
   input  logic             i_tick,
   output logic             o_busy,
   output logic             o_last
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge i_clk)
      if (!i_reset) r_cnt <= '0;
      else if (i_load) r_cnt <= i_depth;
      else if (i_tick && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_busy = r_cnt != '0;
   assign o_last = r_cnt == CNT_W'(1);
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC, applies branch redirects and flushes younger stages.
// Optional PC_MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_VEC.
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
`ifdef PC_MISALIGN_TRAP_EN
   parameter logic [31:0] TRAP_VEC    = DEF_TRAP_VEC,
`endif
   parameter logic [31:0] RESET_VEC   = DEF_RESET_VEC,
   parameter int          FLUSH_DEPTH = 2
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_branch_sel,
   input  logic [31:0] i_b_pc,
   input  logic        i_stall,
   input  logic        i_imem_ready,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_4,
   output logic        o_flush,
   output logic        o_fetch_valid,
   output logic        o_misalign
);
   localparam state_t REDIR_STATE = (FLUSH_DEPTH > 1) ? FLUSH_S : RUN;
   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt, w_target;
   logic        w_busy, w_last;
`ifdef PC_MISALIGN_TRAP_EN
   logic w_misalign, r_misalign;
   assign w_misalign = |i_b_pc[1:0];
   assign w_target   = w_misalign ? TRAP_VEC : i_b_pc;
   always_ff @(posedge i_clk)
      if (!i_reset) r_misalign <= 1'b0;
      else r_misalign <= i_branch_sel & w_misalign;
   assign o_misalign = r_misalign;
`else
   assign w_target   = i_b_pc & ~32'h3;
   assign o_misalign = 1'b0;
`endif
   redirect_flush_counter u_flush_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (i_branch_sel),
      .i_depth (CNT_W'(FLUSH_DEPTH - 1)),
      .i_tick  (r_state == FLUSH_S),
      .o_busy  (w_busy),
      .o_last  (w_last)
   );
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      if (i_branch_sel) begin
         w_pc_nxt    = w_target;
         w_state_nxt = REDIR_STATE;
      end else begin
         unique case (r_state)
            FLUSH_S: begin
               w_state_nxt = w_last ? RUN : FLUSH_S;
               w_pc_nxt    = (i_imem_ready && !i_stall) ? o_pc_4 : r_pc;
            end
            MEM_WAIT: if (!i_stall && i_imem_ready) begin
               w_pc_nxt    = o_pc_4;
               w_state_nxt = RUN;
            end
            default: if (!i_stall) begin
               w_pc_nxt    = i_imem_ready ? o_pc_4 : r_pc;
               w_state_nxt = i_imem_ready ? RUN : MEM_WAIT;
            end
         endcase
      end
   end
   always_ff @(posedge i_clk)
      if (!i_reset) begin
         r_state <= RUN;
         r_pc    <= RESET_VEC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   assign o_pc          = r_pc;
   assign o_pc_4        = seq_pc(r_pc);
   assign o_flush       = i_branch_sel | w_busy;
   assign o_fetch_valid = i_reset & i_imem_ready & ~o_flush & ~i_stall;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and randomized checks of pc_redirect_unit against
// a cycle-level model; honours PC_MISALIGN_TRAP_EN when defined.
module tb_pc_redirect_unit;
   localparam int          DEPTH = 2;
   localparam logic [31:0] RVEC  = 32'h0000_0000;
   localparam logic [31:0] TVEC  = 32'h0000_0100;
   logic        clk, rst_n, br, st, rdy;
   logic [31:0] bpc;
   logic [31:0] o_pc, o_pc_4;
   logic        o_flush, o_fetch_valid, o_misalign;
   int          n_tests, n_fail;
   logic [31:0] m_pc;
   int          m_cnt;
   logic        m_mis, m_ok;

   pc_redirect_unit #(.FLUSH_DEPTH(DEPTH)) dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_branch_sel  (br),
      .i_b_pc        (bpc),
      .i_stall       (st),
      .i_imem_ready  (rdy),
      .o_pc          (o_pc),
      .o_pc_4        (o_pc_4),
      .o_flush       (o_flush),
      .o_fetch_valid (o_fetch_valid),
      .o_misalign    (o_misalign)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] target_of(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
      return (t % 4 != 0) ? TVEC : t;
`else
      return t - (t % 4);
`endif
   endfunction

   function automatic logic mis_of(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
      return t % 4 != 0;
`else
      return (t != t) ? 1'b1 : 1'b0;
`endif
   endfunction

   // Model: PC moves on redirect or on ready-and-not-stalled; flush lingers DEPTH-1 cycles.
   always @(posedge clk) begin
      m_ok <= 1'b1;
      if (!rst_n) begin
         m_pc  <= RVEC;
         m_cnt <= 0;
         m_mis <= 1'b0;
      end else if (br) begin
         m_pc  <= target_of(bpc);
         m_cnt <= DEPTH - 1;
         m_mis <= mis_of(bpc);
      end else begin
         m_mis <= 1'b0;
         m_cnt <= (m_cnt > 0) ? m_cnt - 1 : 0;
         if (rdy && !st) m_pc <= m_pc + 32'd4;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   logic exp_flush;
   always @(negedge clk) if (m_ok === 1'b1) begin
      exp_flush = br | (m_cnt != 0);
      chk("pc", o_pc, m_pc);
      chk("pc_4", o_pc_4, m_pc + 32'd4);
      chk("flush", {31'b0, o_flush}, {31'b0, exp_flush});
      chk("fetch_valid", {31'b0, o_fetch_valid}, {31'b0, rst_n & rdy & ~exp_flush & ~st});
      chk("misalign", {31'b0, o_misalign}, {31'b0, m_mis});
   end

   task automatic drive(input logic b, input logic [31:0] t, input logic s, input logic r);
      br = b; bpc = t; st = s; rdy = r;
      @(posedge clk); #2;
      br = 1'b0;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; m_ok = 1'b0;
      rst_n = 1'b0; br = 1'b0; bpc = '0; st = 1'b0; rdy = 1'b1;
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      rst_n = 1'b1;
      #1 chk("lit_reset_pc", o_pc, 32'h0);
      chk("lit_reset_flush", {31'b0, o_flush}, 32'h0);
      chk("lit_fv_cycle1", {31'b0, o_fetch_valid}, 32'h1);
      drive(0, 0, 0, 1); chk("lit_seq4", o_pc, 32'h4);
      drive(0, 0, 0, 1); chk("lit_seq8", o_pc, 32'h8);
      drive(1, 32'h40, 0, 1); #1;
      chk("lit_redir_pc", o_pc, 32'h40);
      chk("lit_redir_flush2", {31'b0, o_flush}, 32'h1);
      drive(0, 0, 0, 1); #1;
      chk("lit_after_flush_pc", o_pc, 32'h44);
      chk("lit_after_flush", {31'b0, o_flush}, 32'h0);
      drive(1, 32'h80, 1, 1); chk("lit_stall_redir", o_pc, 32'h80);
      drive(0, 0, 1, 1);      chk("lit_stall_hold", o_pc, 32'h80);
      drive(0, 0, 0, 1);      chk("lit_stall_release", o_pc, 32'h84);
      drive(1, 32'h10, 0, 1);
      repeat (3) drive(0, 0, 0, 0);
      #1 chk("lit_wait_hold", o_pc, 32'h10);
      chk("lit_wait_fv", {31'b0, o_fetch_valid}, 32'h0);
      drive(0, 0, 0, 1); chk("lit_wait_done", o_pc, 32'h14);
      drive(1, 32'hFFFF_FFFC, 0, 1); chk("lit_wrap_pre", o_pc, 32'hFFFF_FFFC);
      chk("lit_wrap_pc4", o_pc_4, 32'h0);
      drive(0, 0, 0, 1); chk("lit_wrap", o_pc, 32'h0);
      drive(1, 32'h42, 0, 1); #1;
`ifdef PC_MISALIGN_TRAP_EN
      chk("lit_mis_pc", o_pc, 32'h100);
      chk("lit_mis_flag", {31'b0, o_misalign}, 32'h1);
`else
      chk("lit_mis_pc", o_pc, 32'h40);
      chk("lit_mis_flag", {31'b0, o_misalign}, 32'h0);
`endif
      drive(0, 0, 0, 1); chk("lit_mis_clear", {31'b0, o_misalign}, 32'h0);
      drive(1, 32'h200, 0, 1);
      rst_n = 1'b0;
      drive(1, 32'h300, 0, 1); #1;
      chk("lit_rst_mid_pc", o_pc, 32'h0);
      chk("lit_rst_mid_flush", {31'b0, o_flush}, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         drive($urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) != 0);
      end
      rst_n = 1'b1;
      drive(0, 0, 0, 1);
      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
